// File: rtl/lif_neuron_array.sv
// lif_neuron_array
//   N_CH independent leaky integrate-and-fire neurons advanced together on a
//   shared timestep strobe. Each channel has its own programmable threshold.
//   The leak mode, post-spike reset mode and refractory length are global and
//   are sampled when the timestep strobe is seen. Spikes appear as one-cycle
//   pulses and are also queued into a valid/ready event port, which presents
//   the lowest pending channel first.
//
// Ports
//   clk, reset    clock; synchronous active-high reset
//   step_i        advance every channel by one timestep this cycle
//   current_i     per-channel unsigned input current, channel c at [c*IN_W +: IN_W]
//   cfg_we/cfg_ch/cfg_thresh  threshold write port (a threshold of 0 disables the channel)
//   leak_mode     0: v -= v >> LEAK_SHIFT    1: v -= LEAK_SUB, floored at 0
//   reset_mode    0: v <= 0 on spike         1: v <= sum - thresh on spike
//   refrac_len    number of refractory timesteps that follow a spike
//   spike_o       one-cycle spike pulses, high the cycle after the step
//   membrane_o    registered membrane values, channel c at [c*W +: W]
//   refrac_o      channel is inside its refractory period
//   evt_valid/evt_ready/evt_ch  spike event port, lowest pending channel first
//   evt_overflow  sticky flag: a spike landed on a channel whose event was still pending
module lif_neuron_array #(
    parameter int N_CH        = 4,
    parameter int IN_W        = 6,
    parameter int W           = 8,
    parameter int REFRAC_W    = 4,
    parameter int LEAK_SHIFT  = 1,
    parameter int LEAK_SUB    = 1,
    parameter int THRESH_INIT = 32,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 step_i,
    input  logic [N_CH*IN_W-1:0] current_i,
    input  logic                 cfg_we,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [W-1:0]         cfg_thresh,
    input  logic                 leak_mode,
    input  logic                 reset_mode,
    input  logic [REFRAC_W-1:0]  refrac_len,
    output logic [N_CH-1:0]      spike_o,
    output logic [N_CH*W-1:0]    membrane_o,
    output logic [N_CH-1:0]      refrac_o,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [CH_W-1:0]      evt_ch,
    output logic                 evt_overflow
);

    localparam logic [W-1:0] SAT_MAX = {W{1'b1}};

    logic [W-1:0]        v_q      [N_CH];
    logic [W-1:0]        v_d      [N_CH];
    logic [REFRAC_W-1:0] cnt_q    [N_CH];
    logic [REFRAC_W-1:0] cnt_d    [N_CH];
    logic [W-1:0]        thresh_q [N_CH];
    logic [W-1:0]        thresh_d [N_CH];
    logic [N_CH-1:0]     spike_q;
    logic [N_CH-1:0]     spike_d;
    logic [N_CH-1:0]     refrac_q;
    logic [N_CH-1:0]     refrac_d;
    logic [N_CH-1:0]     pend_q;
    logic [N_CH-1:0]     pend_d;
    logic                evt_overflow_q;
    logic                evt_overflow_d;

    logic [W-1:0]        vl_s     [N_CH];
    logic [W:0]          sum_s    [N_CH];
    logic [W-1:0]        sat_s    [N_CH];
    logic [CH_W-1:0]     evt_ch_s;
    logic [N_CH-1:0]     clear_s;

    // Leak then integrate: sum is formed one bit wider so the carry can saturate it.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            if (leak_mode) begin
                vl_s[c] = (v_q[c] >= W'(LEAK_SUB)) ? (v_q[c] - W'(LEAK_SUB)) : {W{1'b0}};
            end else begin
                vl_s[c] = v_q[c] - (v_q[c] >> LEAK_SHIFT);
            end
            sum_s[c] = {1'b0, vl_s[c]} + (W+1)'(current_i[c*IN_W +: IN_W]);
            sat_s[c] = sum_s[c][W] ? SAT_MAX : sum_s[c][W-1:0];
        end
    end

    // Per-channel timestep update and threshold configuration.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            v_d[c]     = v_q[c];
            cnt_d[c]   = cnt_q[c];
            spike_d[c] = 1'b0;
            if (step_i) begin
                if (thresh_q[c] == {W{1'b0}}) begin
                    v_d[c]   = {W{1'b0}};
                    cnt_d[c] = {REFRAC_W{1'b0}};
                end else if (cnt_q[c] != {REFRAC_W{1'b0}}) begin
                    cnt_d[c] = cnt_q[c] - {{(REFRAC_W-1){1'b0}}, 1'b1};
                end else if (sat_s[c] >= thresh_q[c]) begin
                    spike_d[c] = 1'b1;
                    v_d[c]     = reset_mode ? (sat_s[c] - thresh_q[c]) : {W{1'b0}};
                    cnt_d[c]   = refrac_len;
                end else begin
                    v_d[c] = sat_s[c];
                end
            end else begin
                v_d[c] = v_q[c];
            end
            refrac_d[c] = (cnt_d[c] != {REFRAC_W{1'b0}});
            // The step in this cycle still sees thresh_q, so a write lands for the next step.
            if (cfg_we && (int'(cfg_ch) == c)) begin
                thresh_d[c] = cfg_thresh;
            end else begin
                thresh_d[c] = thresh_q[c];
            end
        end
    end

    // Lowest pending channel: a descending scan lets the lowest index win.
    always_comb begin
        evt_ch_s = {CH_W{1'b0}};
        for (int c = N_CH - 1; c >= 0; c--) begin
            evt_ch_s = pend_q[c] ? CH_W'(c) : evt_ch_s;
        end
    end

    // Event queue: the clear is applied before new spikes, so clear-and-respike stays pending.
    always_comb begin
        clear_s = {N_CH{1'b0}};
        if (evt_valid && evt_ready) begin
            clear_s[evt_ch_s] = 1'b1;
        end else begin
            clear_s = {N_CH{1'b0}};
        end
        pend_d         = (pend_q & ~clear_s) | spike_d;
        evt_overflow_d = evt_overflow_q | (|(spike_d & pend_q & ~clear_s));
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < N_CH; c++) begin
                v_q[c]      <= {W{1'b0}};
                cnt_q[c]    <= {REFRAC_W{1'b0}};
                thresh_q[c] <= W'(THRESH_INIT);
            end
            spike_q        <= {N_CH{1'b0}};
            refrac_q       <= {N_CH{1'b0}};
            pend_q         <= {N_CH{1'b0}};
            evt_overflow_q <= 1'b0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                v_q[c]      <= v_d[c];
                cnt_q[c]    <= cnt_d[c];
                thresh_q[c] <= thresh_d[c];
            end
            spike_q        <= spike_d;
            refrac_q       <= refrac_d;
            pend_q         <= pend_d;
            evt_overflow_q <= evt_overflow_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_mem
            assign membrane_o[g*W +: W] = v_q[g];
        end
    endgenerate

    assign spike_o      = spike_q;
    assign refrac_o     = refrac_q;
    assign evt_valid    = |pend_q;
    assign evt_ch       = evt_ch_s;
    assign evt_overflow = evt_overflow_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Randomised and directed bench for lif_neuron_array, compared each cycle
// against a behavioural model built from the neuron rules using plain integers.
module tb_lif_neuron_array;

    localparam int N  = 4;
    localparam int IW = 6;
    localparam int VW = 8;
    localparam int RW = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            step_i = 1'b0;
    logic [N*IW-1:0] current_i = '0;
    logic            cfg_we = 1'b0;
    logic [1:0]      cfg_ch = 2'd0;
    logic [VW-1:0]   cfg_thresh = 8'd0;
    logic            leak_mode = 1'b0;
    logic            reset_mode = 1'b0;
    logic [RW-1:0]   refrac_len = 4'd0;
    logic [N-1:0]    spike_o;
    logic [N*VW-1:0] membrane_o;
    logic [N-1:0]    refrac_o;
    logic            evt_valid;
    logic            evt_ready = 1'b0;
    logic [1:0]      evt_ch;
    logic            evt_overflow;

    lif_neuron_array dut (
        .clk(clk), .reset(reset), .step_i(step_i), .current_i(current_i),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_thresh(cfg_thresh),
        .leak_mode(leak_mode), .reset_mode(reset_mode), .refrac_len(refrac_len),
        .spike_o(spike_o), .membrane_o(membrane_o), .refrac_o(refrac_o),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch),
        .evt_overflow(evt_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_v [N];
    int m_cnt [N];
    int m_th [N];
    int m_spk [N];
    int m_pend [N];
    int m_ovf;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int cur_of(input int c);
        logic [N*IW-1:0] tmp;
        tmp = current_i;
        return int'(tmp[c*IW +: IW]);
    endfunction

    // One clock: predict the next model state from the current inputs, clock, then compare.
    task automatic tick();
        int nv [N];
        int nc [N];
        int nth [N];
        int ns [N];
        int np [N];
        int novf;
        int lowest;
        int vl;
        int s;
        lowest = -1;
        for (int c = N - 1; c >= 0; c--) if (m_pend[c] != 0) lowest = c;
        if (reset) begin
            for (int c = 0; c < N; c++) begin
                nv[c] = 0; nc[c] = 0; nth[c] = 32; ns[c] = 0; np[c] = 0;
            end
            novf = 0;
        end else begin
            novf = m_ovf;
            for (int c = 0; c < N; c++) begin
                nv[c] = m_v[c]; nc[c] = m_cnt[c]; nth[c] = m_th[c]; ns[c] = 0;
                if (step_i) begin
                    if (m_th[c] == 0) begin
                        nv[c] = 0; nc[c] = 0;
                    end else if (m_cnt[c] > 0) begin
                        nc[c] = m_cnt[c] - 1;
                    end else begin
                        if (leak_mode) vl = (m_v[c] > 1) ? m_v[c] - 1 : 0;
                        else           vl = m_v[c] - m_v[c] / 2;
                        s = vl + cur_of(c);
                        if (s > 255) s = 255;
                        if (s >= m_th[c]) begin
                            ns[c] = 1;
                            nv[c] = reset_mode ? s - m_th[c] : 0;
                            nc[c] = int'(refrac_len);
                        end else begin
                            nv[c] = s;
                        end
                    end
                end
                np[c] = m_pend[c];
                if (evt_ready && lowest == c) np[c] = 0;
                if (ns[c] != 0) begin
                    if (np[c] != 0) novf = 1;
                    np[c] = 1;
                end
            end
            if (cfg_we) nth[int'(cfg_ch)] = int'(cfg_thresh);
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < N; c++) begin
            m_v[c] = nv[c]; m_cnt[c] = nc[c]; m_th[c] = nth[c];
            m_spk[c] = ns[c]; m_pend[c] = np[c];
        end
        m_ovf = novf;
        lowest = -1;
        for (int c = N - 1; c >= 0; c--) if (m_pend[c] != 0) lowest = c;
        for (int c = 0; c < N; c++) begin
            check_val($sformatf("membrane%0d", c), int'(membrane_o[c*VW +: VW]), m_v[c]);
            check_val($sformatf("spike%0d", c), int'(spike_o[c]), m_spk[c]);
            check_val($sformatf("refrac%0d", c), int'(refrac_o[c]), (m_cnt[c] != 0) ? 1 : 0);
        end
        check_val("evt_valid", int'(evt_valid), (lowest >= 0) ? 1 : 0);
        if (lowest >= 0) check_val("evt_ch", int'(evt_ch), lowest);
        check_val("evt_overflow", int'(evt_overflow), m_ovf);
    endtask

    task automatic set_cur(input int c, input int val);
        current_i[c*IW +: IW] = IW'(val);
    endtask

    task automatic do_reset();
        reset = 1'b1; step_i = 1'b0; cfg_we = 1'b0; evt_ready = 1'b0;
        current_i = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic write_thresh(input int c, input int th);
        cfg_we = 1'b1; cfg_ch = 2'(c); cfg_thresh = 8'(th); step_i = 1'b0;
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        int t2_exp [8];
        int t4_v [4];
        int t4_s [4];
        t2_exp = '{10, 15, 18, 19, 20, 20, 20, 20};
        t4_v   = '{20, 7, 26, 13};
        t4_s   = '{0, 1, 0, 1};

        // 1: reset and idle, then every channel fires at 32 but not at 31
        do_reset();
        tick();
        check_val("t1_idle_mem", int'(membrane_o), 0);
        check_val("t1_idle_evt", int'(evt_valid), 0);
        for (int c = 0; c < N; c++) set_cur(c, 31);
        step_i = 1'b1; tick(); step_i = 1'b0;
        check_val("t1_no_spike31", int'(spike_o), 0);
        do_reset();
        for (int c = 0; c < N; c++) set_cur(c, 32);
        step_i = 1'b1; tick(); step_i = 1'b0;
        check_val("t1_spike32", int'(spike_o), 15);

        // 2: shift leak integration to a fixed point
        do_reset();
        leak_mode = 1'b0; reset_mode = 1'b0; refrac_len = 4'd0;
        set_cur(0, 10);
        step_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_val("t2_v", int'(membrane_o[7:0]), t2_exp[i]);
        end
        step_i = 1'b0;
        tick();
        check_val("t2_hold", int'(membrane_o[7:0]), 20);

        // 3: refractory period of 2 steps after each spike
        do_reset();
        set_cur(0, 40); refrac_len = 4'd2;
        step_i = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check_val("t3_spike", int'(spike_o[0]), (i % 3 == 1) ? 1 : 0);
        end
        step_i = 1'b0; evt_ready = 1'b1; tick(); evt_ready = 1'b0;

        // 4: subtractive leak with subtract-on-spike reset
        do_reset();
        leak_mode = 1'b1; reset_mode = 1'b1; refrac_len = 4'd0;
        set_cur(0, 20);
        step_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("t4_v", int'(membrane_o[7:0]), t4_v[i]);
            check_val("t4_spike", int'(spike_o[0]), t4_s[i]);
        end
        step_i = 1'b0;

        // 5: high threshold with large input, then a disabled channel
        do_reset();
        leak_mode = 1'b0; reset_mode = 1'b0;
        write_thresh(0, 255);
        set_cur(0, 63);
        step_i = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        step_i = 1'b0;
        write_thresh(0, 0);
        step_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("t5_disabled", int'(membrane_o[7:0]), 0);
        end
        step_i = 1'b0;

        // 6: event ordering and overflow
        do_reset();
        refrac_len = 4'd0;
        write_thresh(0, 0);
        write_thresh(2, 0);
        set_cur(1, 40); set_cur(3, 40);
        step_i = 1'b1; tick(); step_i = 1'b0;
        check_val("t6_first", int'(evt_ch), 1);
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        check_val("t6_second", int'(evt_ch), 3);
        step_i = 1'b1; tick(); step_i = 1'b0;
        check_val("t6_overflow", int'(evt_overflow), 1);
        for (int i = 0; i < 4; i++) begin
            evt_ready = 1'b1; tick();
        end
        evt_ready = 1'b0;

        // Randomised traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 199) == 0);
            step_i     = ($urandom_range(0, 1) == 1);
            current_i  = N*IW'($urandom);
            leak_mode  = ($urandom_range(0, 1) == 1);
            reset_mode = ($urandom_range(0, 1) == 1);
            refrac_len = RW'($urandom_range(0, 3));
            evt_ready  = ($urandom_range(0, 2) == 0);
            cfg_we     = ($urandom_range(0, 9) == 0);
            cfg_ch     = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       cfg_thresh = 8'd0;
                1:       cfg_thresh = 8'($urandom_range(1, 40));
                2:       cfg_thresh = 8'($urandom_range(200, 255));
                default: cfg_thresh = 8'($urandom);
            endcase
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
